ip_rewrite_flow_tbl_arb: RTL
============================

// Module: ip_rewrite_flow_tbl_arb
// PURPOSE
//  Owns the IP-rewrite flow table and shares it between two lookup requesters (RX and TX rewrite pipes) and one config write port.
//  Each lookup presents a flow_lookup_tuple and gets {hit, rewrite address} back one cycle after acceptance.
//  Sits beside the rewrite NoC pipes; replaces per-pipe private tables with one arbitrated, single-issue table.
// PARAMETERS
//  TABLE_DEPTH  8                          number of flow entries
//  IDX_W        $clog2(TABLE_DEPTH)        entry index width
// PORTS
//  clk              in   1                    clock
//  rst              in   1                    reset, asynchronous, active-high
//  cfg_wr_val       in   1                    config write request
//  cfg_wr_idx       in   IDX_W                entry to write
//  cfg_wr_entry_val in   1                    1 = install entry, 0 = invalidate entry
//  cfg_wr_tuple     in   FLOW_LOOKUP_TUPLE_W  match key
//  cfg_wr_new_addr  in   `IP_ADDR_W           rewrite address for entry
//  cfg_wr_rdy       out  1                    write accepted when val&rdy
//  req{0,1}_val     in   1                    lookup request, requester 0/1
//  req{0,1}_tuple   in   FLOW_LOOKUP_TUPLE_W  lookup key
//  req{0,1}_rdy     out  1                    lookup accepted when val&rdy
//  resp{0,1}_val    out  1                    lookup result valid
//  resp{0,1}_hit    out  1                    1 = matching valid entry found
//  resp{0,1}_addr   out  `IP_ADDR_W           rewrite address, 0 on miss
//  resp{0,1}_rdy    in   1                    result consumed when val&rdy
// BEHAVIOUR
//  - Table: TABLE_DEPTH x {valid, tuple, new_addr}, flops. Reset: all valid=0; contents don't-care.
//  - Match: fully parallel compare of valid entries. Lowest matching index wins on duplicates.
//  - One table operation per cycle. Order: cfg write, then lookups.
//  - Anti-starvation: flag last_cfg is set on a write cycle. If last_cfg=1 and any lookup is eligible, cfg_wr_rdy=0 for that cycle.
//  - Requester i is eligible when req_i_val and its response slot is free. Free means resp_i_val=0, or resp_i_val&resp_i_rdy this cycle.
//  - Lookups, both eligible: round-robin pointer rr picks the winner; after each grant rr points to the loser.
//  - Lookups, one eligible: that one is granted; rr is unchanged.
//  - req_i_rdy = granted_i (combinational). cfg_wr_rdy is combinational from the flags and eligibility.
//  - Latency: lookup accepted at cycle N -> resp_i_val=1 at N+1, using table contents as of end of N.
//  - A cfg write at cycle N is visible to lookups accepted at N+1 or later.
//  - Response held stable while resp_i_val & !resp_i_rdy. A stalled requester never blocks the other.
//  - Reset values: resp_val=0, resp_hit=0, resp_addr=0, rr=0 (req0 first), last_cfg=0.
//  - Reset mid-operation: in-flight responses are dropped and the table is cleared.
// CONFIGURATION
//  IP_REWRITE_FLOW_ARB_STATS_EN defined: adds lookup_cnt[31:0], hit_cnt[31:0], cfg_wr_cnt[31:0] outputs.
//   - Counters increment on each accepted lookup / hit response issued / accepted write.
//   - Counters wrap at 2^32 and reset to 0.
//  IP_REWRITE_FLOW_ARB_STATS_EN undefined: counter ports and logic absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package ip_rewrite_noc_pipe_pkg gains:
//   - typedef flow_tbl_entry {valid, flow_lookup_tuple tuple, new_addr}.
//   - typedef flow_tbl_resp {hit, addr}.
//  flow_lookup_tuple is reused unchanged.
//  Sub-module ip_rewrite_flow_tbl_match (combinational): entries + key -> {hit, idx, addr}, lowest-index priority encode.
//  It is instantiated once, fed by the granted key.
// TESTING
//  1. After reset: req0 tuple {0x0A000001,80,1234} -> resp0 one cycle later, hit=0 addr=0.
//  2. Write idx3 {0x0A000001,80,1234}->0xC0A80005, then req1 same tuple -> hit=1, addr=0xC0A80005, 1 cycle after accept.
//  3. req0, req1 held valid, resp rdy=1 -> grants alternate 0,1,0,1 starting with 0.
//  4. resp0_rdy=0 with resp0 pending: req0_rdy=0 and resp0 held stable; req1 still served every cycle; resp0_rdy=1 resumes req0.
//  5. cfg_wr_val held high with req0 valid -> write, lookup, write, lookup. Lookup after invalidating write of idx3 -> hit=0.
//  6. Same tuple at idx2 (addr A) and idx5 (addr B) -> returns A; invalidate idx2 -> returns B; stats (if enabled) lookup=2, hit=2.

Source files
------------

// File: rtl/ip_rewrite_flow_tbl_arb_pkg.sv
// Shared IP-rewrite pipe types: lookup tuple plus the flow-table entry and response records.
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif

package ip_rewrite_flow_tbl_arb_pkg;
  localparam int IP_ADDR_W = `IP_ADDR_W;
  localparam int NUM_REQ   = 2;

  typedef struct packed {
    logic [31:0] dst_ip;
    logic [15:0] dst_port;
    logic [15:0] src_port;
  } flow_lookup_tuple;

  localparam int FLOW_LOOKUP_TUPLE_W = $bits(flow_lookup_tuple);

  typedef struct packed {
    logic                 valid;
    flow_lookup_tuple     tuple;
    logic [IP_ADDR_W-1:0] new_addr;
  } flow_tbl_entry;

  typedef struct packed {
    logic                 hit;
    logic [IP_ADDR_W-1:0] addr;
  } flow_tbl_resp;
endpackage

// File: rtl/ip_rewrite_flow_tbl_arb_if.sv
// Flow-table bus: one config write port and two lookup request/response channels.
interface ip_rewrite_flow_tbl_arb_if #(
  parameter int TABLE_DEPTH = 8,
  parameter int IDX_W       = $clog2(TABLE_DEPTH)
);
  import ip_rewrite_flow_tbl_arb_pkg::*;

  logic                 cfg_wr_val;
  logic [IDX_W-1:0]     cfg_wr_idx;
  logic                 cfg_wr_entry_val;
  flow_lookup_tuple     cfg_wr_tuple;
  logic [IP_ADDR_W-1:0] cfg_wr_new_addr;
  logic                 cfg_wr_rdy;

  logic                 req0_val, req1_val;
  flow_lookup_tuple     req0_tuple, req1_tuple;
  logic                 req0_rdy, req1_rdy;

  logic                 resp0_val, resp1_val;
  logic                 resp0_hit, resp1_hit;
  logic [IP_ADDR_W-1:0] resp0_addr, resp1_addr;
  logic                 resp0_rdy, resp1_rdy;

  modport master (
    output cfg_wr_val, cfg_wr_idx, cfg_wr_entry_val, cfg_wr_tuple, cfg_wr_new_addr,
    input  cfg_wr_rdy,
    output req0_val, req0_tuple, req1_val, req1_tuple,
    input  req0_rdy, req1_rdy,
    input  resp0_val, resp0_hit, resp0_addr, resp1_val, resp1_hit, resp1_addr,
    output resp0_rdy, resp1_rdy
  );

  modport slave (
    input  cfg_wr_val, cfg_wr_idx, cfg_wr_entry_val, cfg_wr_tuple, cfg_wr_new_addr,
    output cfg_wr_rdy,
    input  req0_val, req0_tuple, req1_val, req1_tuple,
    output req0_rdy, req1_rdy,
    output resp0_val, resp0_hit, resp0_addr, resp1_val, resp1_hit, resp1_addr,
    input  resp0_rdy, resp1_rdy
  );
endinterface

// File: rtl/ip_rewrite_flow_tbl_arb_match.sv
// Parallel flow-table match: compares key against every valid entry, lowest index wins.
module ip_rewrite_flow_tbl_match
  import ip_rewrite_flow_tbl_arb_pkg::*;
#(
  parameter int TABLE_DEPTH = 8,
  parameter int IDX_W       = $clog2(TABLE_DEPTH)
) (
  input  flow_tbl_entry [TABLE_DEPTH-1:0] entries,
  input  flow_lookup_tuple                key,
  output logic                            hit,
  output logic [IDX_W-1:0]                idx,
  output logic [IP_ADDR_W-1:0]            addr
);
  logic [TABLE_DEPTH-1:0] match;

  for (genvar e = 0; e < TABLE_DEPTH; e++) begin : g_cmp
    assign match[e] = entries[e].valid && (entries[e].tuple == key);
  end

  assign hit = |match;

  // Scan high to low so the lowest matching index is the last one written.
  always_comb begin
    idx  = '0;
    addr = '0;
    for (int e = TABLE_DEPTH-1; e >= 0; e--) begin
      if (match[e]) begin
        idx  = IDX_W'(e);
        addr = entries[e].new_addr;
      end
    end
  end
endmodule

// File: rtl/ip_rewrite_flow_tbl_arb.sv
// Arbitrated IP-rewrite flow table: cfg writes plus two round-robin lookup requesters, one op/cycle.
// Define IP_REWRITE_FLOW_ARB_STATS_EN to add lookup/hit/cfg-write counters.
module ip_rewrite_flow_tbl_arb
  import ip_rewrite_flow_tbl_arb_pkg::*;
#(
  parameter int TABLE_DEPTH = 8,
  parameter int IDX_W       = $clog2(TABLE_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  ip_rewrite_flow_tbl_arb_if.slave     bus
`ifdef IP_REWRITE_FLOW_ARB_STATS_EN
  ,
  output logic [31:0]                  lookup_cnt,
  output logic [31:0]                  hit_cnt,
  output logic [31:0]                  cfg_wr_cnt
`endif
);
  logic [TABLE_DEPTH-1:0]         tbl_vld;
  flow_lookup_tuple               tbl_tuple [TABLE_DEPTH];
  logic [IP_ADDR_W-1:0]           tbl_addr  [TABLE_DEPTH];
  flow_tbl_entry [TABLE_DEPTH-1:0] entries;

  logic [NUM_REQ-1:0]             req_val, resp_rdy, resp_val, elig, gnt;
  flow_lookup_tuple [NUM_REQ-1:0] req_tuple;
  flow_tbl_resp [NUM_REQ-1:0]     resp;
  flow_lookup_tuple               key;
  logic                           rr, last_cfg, cfg_fire, contend;
  logic                           m_hit;
  logic [IP_ADDR_W-1:0]           m_addr;
  logic [IDX_W-1:0]               m_idx_unused;

  assign req_val   = {bus.req1_val, bus.req0_val};
  assign req_tuple = {bus.req1_tuple, bus.req0_tuple};
  assign resp_rdy  = {bus.resp1_rdy, bus.resp0_rdy};

  // A requester may only win when its single response slot drains this cycle or is empty.
  assign elig    = req_val & (~resp_val | resp_rdy);
  assign contend = &elig;

  assign bus.cfg_wr_rdy = !(last_cfg && |elig);
  assign cfg_fire       = bus.cfg_wr_val && bus.cfg_wr_rdy;

  always_comb begin
    gnt = '0;
    if (!cfg_fire) begin
      if (contend) gnt[rr] = 1'b1;
      else         gnt     = elig;
    end
  end

  assign bus.req0_rdy = gnt[0];
  assign bus.req1_rdy = gnt[1];
  assign key          = gnt[1] ? req_tuple[1] : req_tuple[0];

  always_comb begin
    for (int e = 0; e < TABLE_DEPTH; e++) begin
      entries[e].valid    = tbl_vld[e];
      entries[e].tuple    = tbl_tuple[e];
      entries[e].new_addr = tbl_addr[e];
    end
  end

  // Address comes straight from the encoder; the index output is not needed here.
  ip_rewrite_flow_tbl_match #(.TABLE_DEPTH(TABLE_DEPTH), .IDX_W(IDX_W)) u_match (
    .entries (entries),
    .key     (key),
    .hit     (m_hit),
    .idx     (m_idx_unused),
    .addr    (m_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           tbl_vld                 <= '0;
    else if (cfg_fire) tbl_vld[bus.cfg_wr_idx] <= bus.cfg_wr_entry_val;
  end

  always_ff @(posedge clk) begin
    if (cfg_fire) begin
      tbl_tuple[bus.cfg_wr_idx] <= bus.cfg_wr_tuple;
      tbl_addr[bus.cfg_wr_idx]  <= bus.cfg_wr_new_addr;
    end
  end

  // rr flips only on contended grants, leaving it pointing at the loser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr       <= 1'b0;
      last_cfg <= 1'b0;
    end else begin
      last_cfg <= cfg_fire;
      if (contend && !cfg_fire) rr <= ~rr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_val <= '0;
      resp     <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (gnt[r]) begin
          resp_val[r]  <= 1'b1;
          resp[r].hit  <= m_hit;
          resp[r].addr <= m_addr;
        end else if (resp_rdy[r]) begin
          resp_val[r]  <= 1'b0;
        end
      end
    end
  end

  assign bus.resp0_val  = resp_val[0];
  assign bus.resp0_hit  = resp[0].hit;
  assign bus.resp0_addr = resp[0].addr;
  assign bus.resp1_val  = resp_val[1];
  assign bus.resp1_hit  = resp[1].hit;
  assign bus.resp1_addr = resp[1].addr;

`ifdef IP_REWRITE_FLOW_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lookup_cnt <= '0;
      hit_cnt    <= '0;
      cfg_wr_cnt <= '0;
    end else begin
      if (|gnt)          lookup_cnt <= lookup_cnt + 32'd1;
      if (|gnt && m_hit) hit_cnt    <= hit_cnt + 32'd1;
      if (cfg_fire)      cfg_wr_cnt <= cfg_wr_cnt + 32'd1;
    end
  end
`endif
endmodule
